// File: rtl/uart_frame_loader_if.sv
// -----------------------------------------------------------------------------
// uart_frame_loader_if
//
// Purpose: Frame-buffer write port that uart_frame_loader drives.
//   It carries one 8-bit grayscale pixel per write strobe.
//
// Signals:
//   wr_en    - write strobe, high for exactly one cycle per pixel
//   wr_addr  - pixel address in raster order (ADDR_W bits)
//   wr_data  - 8-bit pixel value
//
// Modports:
//   master - the pixel producer (uart_frame_loader)
//   slave  - the frame-buffer RAM write port
// -----------------------------------------------------------------------------
interface uart_frame_loader_if #(
  parameter int ADDR_W = 19
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/uart_frame_loader.sv
// -----------------------------------------------------------------------------
// uart_frame_loader
//
// Purpose: Receives 8N1 UART bytes from the host and writes each byte as one
//   grayscale pixel into the frame-buffer RAM. Pixels are written in raster
//   order starting at address 0. A start pulse arms the download. The frame
//   completes after NUM_PIXELS writes.
//
// Ports:
//   clk_50      in   system clock
//   rst_n       in   asynchronous active-low reset
//   rx          in   UART serial input, idle high, asynchronous to clk_50
//   start       in   one-cycle pulse that arms or restarts a frame load
//   fb          out  frame-buffer write port (uart_frame_loader_if.master)
//   busy        out  high while a frame load is in progress
//   frame_done  out  high from frame completion until the next start
//   frame_err   out  sticky framing-error flag, cleared by start or reset
//   checksum    out  (FRAME_CHECKSUM_EN only) sum of written pixels, mod 256
//
// Optional feature: define FRAME_CHECKSUM_EN to add the checksum output.
//   This macro also adds the adder logic behind that output.
// -----------------------------------------------------------------------------
module uart_frame_loader #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int NUM_PIXELS = 307200,
  parameter int ADDR_W     = 19
) (
  input  logic                clk_50,
  input  logic                rst_n,
  input  logic                rx,
  input  logic                start,
  uart_frame_loader_if.master fb,
  output logic                busy,
  output logic                frame_done,
  output logic                frame_err
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic [7:0]          checksum
`endif
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_PIXELS - 1);

  // ---------------------------------------------------------------------------
  // rx synchronizer. It resets to the idle-high level so that reset itself
  // never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic       rx_s;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  // ---------------------------------------------------------------------------
  // UART receive FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT
  } rx_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             framing_err;     // single-cycle, combinational

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    framing_err  = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
          bit_cnt_d  = '0;
        end
      end

      // Re-check the line at mid start bit so short glitches are rejected.
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d      = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // We are now aligned to bit centres. Shift right so that the LSB,
      // which arrives first, ends up in bit 0.
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_valid_d = 1'b1;
            rx_state_d   = RX_IDLE;
          end else begin
            framing_err = 1'b1;
            rx_state_d  = RX_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Wait out a break, or a line held low, so that it is not decoded as
      // a stream of 0x00 bytes.
      RX_WAIT: begin
        if (rx_s) begin
          rx_state_d = RX_IDLE;
        end
      end

      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame loader FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    L_IDLE,
    L_LOAD,
    L_DONE
  } l_state_t;

  l_state_t          l_state_q, l_state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              frame_err_q, frame_err_d;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      l_state_q   <= L_IDLE;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      l_state_q   <= l_state_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    l_state_d   = l_state_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = frame_err_q;

    if (start) begin
      // start takes priority over a byte completing in the same cycle.
      // That byte is dropped.
      l_state_d   = L_LOAD;
      wr_addr_d   = '0;
      frame_err_d = 1'b0;
    end else begin
      case (l_state_q)
        L_LOAD: begin
          // The address advances in the cycle after the write strobe, so
          // the strobe always presents the address it was issued for.
          if (wr_en_q) begin
            if (wr_addr_q == ADDR_LAST) begin
              wr_addr_d = '0;
              l_state_d = L_DONE;
            end else begin
              wr_addr_d = wr_addr_q + 1'b1;
            end
          end
          if (byte_valid_q) begin
            wr_en_d   = 1'b1;
            wr_data_d = shift_q;
          end
        end
        L_IDLE: begin
          // Bytes that arrive before the frame is armed are dropped.
        end
        L_DONE: begin
          // Bytes that arrive after the frame completes are dropped.
        end
        default: begin
          l_state_d = L_IDLE;
        end
      endcase
    end

    // An error detected in the same cycle as start still sets the flag,
    // because that error belongs to the newly armed frame.
    if (framing_err) begin
      frame_err_d = 1'b1;
    end
  end

  assign fb.wr_en    = wr_en_q;
  assign fb.wr_addr  = wr_addr_q;
  assign fb.wr_data  = wr_data_q;
  assign busy        = (l_state_q == L_LOAD);
  assign frame_done  = (l_state_q == L_DONE);
  assign frame_err   = frame_err_q;

`ifdef FRAME_CHECKSUM_EN
  // ---------------------------------------------------------------------------
  // Running pixel checksum. It is updated from the same byte_valid condition
  // that raises wr_en_d, so the new sum is visible in the cycle of the write.
  // ---------------------------------------------------------------------------
  logic [7:0] checksum_q, checksum_d;

  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  always_comb begin
    checksum_d = checksum_q;
    if (start) begin
      checksum_d = '0;
    end else if ((l_state_q == L_LOAD) && byte_valid_q) begin
      checksum_d = checksum_q + shift_q;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_uart_frame_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_loader
//
// Directed bench for uart_frame_loader. It runs with CLKS_PER_BIT = 8 and
// NUM_PIXELS = 4. Frame-buffer writes are logged from the interface at the
// falling clock edge and compared against hand-computed addresses and data.
// When FRAME_CHECKSUM_EN is defined, the bench also checks the checksum
// output.
// -----------------------------------------------------------------------------
module tb_uart_frame_loader;

  localparam int CPB    = 8;
  localparam int ADDR_W = 19;

  logic       clk_50 = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx     = 1'b1;
  logic       start  = 1'b0;
  logic       busy;
  logic       frame_done;
  logic       frame_err;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  uart_frame_loader_if #(.ADDR_W(ADDR_W)) fb ();

  uart_frame_loader #(
    .CLK_HZ     (50000000),
    .BAUD       (6250000),
    .NUM_PIXELS (4),
    .ADDR_W     (ADDR_W)
  ) dut (
    .clk_50     (clk_50),
    .rst_n      (rst_n),
    .rx         (rx),
    .start      (start),
    .fb         (fb),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err)
`ifdef FRAME_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk_50 = ~clk_50;

  int n_checks = 0;
  int n_fail   = 0;

  // Write log and the longest run of consecutive wr_en cycles.
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  int          run_len = 0;
  int          max_run = 0;

  initial begin
    forever begin
      @(negedge clk_50);
      if (fb.wr_en === 1'b1) begin
        log_addr.push_back(32'(fb.wr_addr));
        log_data.push_back(32'(fb.wr_data));
        run_len = run_len + 1;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic check_write(input string tag, input int idx, input logic [31:0] ea, input logic [31:0] ed);
    check_eq({tag, "_addr"}, (idx < log_addr.size()) ? log_addr[idx] : 32'hFFFF_FFFF, ea);
    check_eq({tag, "_data"}, (idx < log_data.size()) ? log_data[idx] : 32'hFFFF_FFFF, ed);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  // Drives one 8N1 frame. The start bit begins 1 time unit after the next
  // rising edge. If stop_bit is 0, the line is left low when the task returns.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    @(posedge clk_50);
    #1;
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (CPB) begin
        @(posedge clk_50);
        #1;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk_50);
    #1 start = 1'b1;
    @(posedge clk_50);
    #1 start = 1'b0;
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    // ---------------- reset state ----------------
    idle(3);
    check_eq("rst_wr_en", 32'(fb.wr_en), 0);
    check_eq("rst_wr_addr", 32'(fb.wr_addr), 0);
    check_eq("rst_wr_data", 32'(fb.wr_data), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_frame_done", 32'(frame_done), 0);
    check_eq("rst_frame_err", 32'(frame_err), 0);
    @(posedge clk_50);
    #1 rst_n = 1'b1;
    idle(4);

    // ---------------- byte with no start: dropped ----------------
    send_byte(8'hAA, 1'b1);
    idle(4);
    check_eq("t2_writes", 32'(log_addr.size()), 0);
    check_eq("t2_busy", 32'(busy), 0);
    check_eq("t2_frame_done", 32'(frame_done), 0);

    // ---------------- full 4-pixel frame ----------------
    clear_log();
    pulse_start();
    #1;
    check_eq("t1_busy_armed", 32'(busy), 1);
    send_byte(8'h12, 1'b1); idle(4);
    send_byte(8'h34, 1'b1); idle(4);
    send_byte(8'h56, 1'b1); idle(4);
    send_byte(8'h78, 1'b1); idle(4);
    check_eq("t1_writes", 32'(log_addr.size()), 4);
    check_write("t1_w0", 0, 0, 32'h12);
    check_write("t1_w1", 1, 1, 32'h34);
    check_write("t1_w2", 2, 2, 32'h56);
    check_write("t1_w3", 3, 3, 32'h78);
    check_eq("t1_wr_en_width", 32'(max_run), 1);
    check_eq("t1_frame_done", 32'(frame_done), 1);
    check_eq("t1_busy", 32'(busy), 0);
    check_eq("t1_addr_wrap", 32'(fb.wr_addr), 0);
`ifdef FRAME_CHECKSUM_EN
    check_eq("t1_checksum", 32'(checksum), 32'h14);
`endif

    // ---------------- framing error, then break ----------------
    clear_log();
    pulse_start();
    send_byte(8'h55, 1'b0);
    idle(40);
    rx = 1'b1;
    idle(4);
    check_eq("t3_err_writes", 32'(log_addr.size()), 0);
    check_eq("t3_frame_err", 32'(frame_err), 1);
    check_eq("t3_addr_hold", 32'(fb.wr_addr), 0);
    send_byte(8'h01, 1'b1);
    idle(4);
    check_eq("t3_writes", 32'(log_addr.size()), 1);
    check_write("t3_w0", 0, 0, 32'h01);

    // ---------------- short glitch ----------------
    clear_log();
    pulse_start();
    idle(2);
    check_eq("t4_err_cleared", 32'(frame_err), 0);
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(30);
    check_eq("t4_writes", 32'(log_addr.size()), 0);
    check_eq("t4_frame_err", 32'(frame_err), 0);
    check_eq("t4_addr", 32'(fb.wr_addr), 0);

    // ---------------- start collides with byte_valid ----------------
    clear_log();
    send_byte(8'h66, 1'b0);
    rx = 1'b1;
    idle(4);
    check_eq("t5_err_set", 32'(frame_err), 1);
    send_byte(8'hA1, 1'b1); idle(4);
    send_byte(8'hB2, 1'b1); idle(4);
    // From the start-bit edge (edge 0), byte_valid is high between edges 79
    // and 80: 2 sync + 4 half-bit + 8x8 data + 8 stop, then the
    // stop-sample register.
    fork
      send_byte(8'hC3, 1'b1);
      begin
        @(posedge clk_50);
        repeat (79) @(posedge clk_50);
        #1 start = 1'b1;
        @(posedge clk_50);
        #1 start = 1'b0;
      end
    join
    idle(4);
    check_eq("t5_writes_pre", 32'(log_addr.size()), 2);
    check_write("t5_w0", 0, 0, 32'hA1);
    check_write("t5_w1", 1, 1, 32'hB2);
    check_eq("t5_addr_restart", 32'(fb.wr_addr), 0);
    check_eq("t5_err_cleared", 32'(frame_err), 0);
    send_byte(8'h9C, 1'b1);
    idle(4);
    check_eq("t5_writes", 32'(log_addr.size()), 3);
    check_write("t5_w2", 2, 0, 32'h9C);

    // ---------------- async reset mid-byte ----------------
    check_eq("t6_busy_pre", 32'(busy), 1);
    rx = 1'b0;
    idle(12);
    rx = 1'b1;
    idle(5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_wr_en", 32'(fb.wr_en), 0);
    check_eq("t6_wr_addr", 32'(fb.wr_addr), 0);
    check_eq("t6_wr_data", 32'(fb.wr_data), 0);
    check_eq("t6_busy", 32'(busy), 0);
    check_eq("t6_frame_done", 32'(frame_done), 0);
    check_eq("t6_frame_err", 32'(frame_err), 0);
    idle(3);
    rst_n = 1'b1;
    idle(4);
    clear_log();
    pulse_start();
    send_byte(8'h11, 1'b1); idle(4);
    send_byte(8'h22, 1'b1); idle(4);
    send_byte(8'h33, 1'b1); idle(4);
    send_byte(8'h44, 1'b1); idle(4);
    check_eq("t6_writes", 32'(log_addr.size()), 4);
    check_write("t6_w0", 0, 0, 32'h11);
    check_write("t6_w1", 1, 1, 32'h22);
    check_write("t6_w2", 2, 2, 32'h33);
    check_write("t6_w3", 3, 3, 32'h44);
    check_eq("t6_frame_done_end", 32'(frame_done), 1);
`ifdef FRAME_CHECKSUM_EN
    check_eq("t6_checksum", 32'(checksum), 32'hAA);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
Upstream feeder for the VGA frame-buffer driver. Receives 8N1 UART bytes from the host PC and writes each byte as one 8-bit grayscale pixel into the 640x480 frame-buffer RAM write port, in raster order from address 0. This replaces build-time image preload with run-time image download. Has a single clock domain, clk_50.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 434 at defaults)
NUM_PIXELS, 307200, pixels per frame (640x480)
ADDR_W, 19, frame-buffer address width; must satisfy 2^ADDR_W >= NUM_PIXELS

Ports:
clk_50  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
rx  input  1  UART serial input, idle high, asynchronous to clk_50
start  input  1  one-cycle pulse that arms a new frame load
wr_en  output  1  frame-buffer write strobe, one cycle per pixel
wr_addr  output  ADDR_W  frame-buffer write address
wr_data  output  8  pixel value
busy  output  1  high while in L_LOAD
frame_done  output  1  high from frame completion until the next start
frame_err  output  1  sticky framing-error flag; cleared by start or reset

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: wr_en=0, wr_addr=0, wr_data=0, busy=0, frame_done=0, frame_err=0.
  - RX FSM goes to RX_IDLE; loader goes to L_IDLE.
  - Synchronizer flops reset to 1.
  - Reset mid-byte or mid-frame aborts everything. Nothing resumes.
- rx passes through a 2-flop synchronizer. All references to rx below mean the synchronized value, which lags the pin by 2 cycles.
- RX FSM states: RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT.
  - RX_IDLE: on rx=0, go to RX_START and clear the bit counter.
  - RX_START: after CLKS_PER_BIT/2 cycles, sample rx. If rx=1 it is a glitch: return to RX_IDLE with no byte. If rx=0, go to RX_DATA.
  - RX_DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first, into a shift register.
  - RX_STOP: sample one CLKS_PER_BIT later.
    - rx=1: the byte is valid. Assert an internal byte_valid pulse for 1 cycle, then go to RX_IDLE.
    - rx=0: framing error. Discard the byte, set frame_err, go to RX_WAIT.
  - RX_WAIT: stay until rx=1, then go to RX_IDLE. This prevents a break condition from being decoded as 0x00 bytes.
- Loader FSM states: L_IDLE, L_LOAD, L_DONE.
  - L_IDLE / L_DONE + start: go to L_LOAD. wr_addr=0, frame_done=0, frame_err=0, busy=1.
  - Bytes that complete in L_IDLE or L_DONE are discarded, with no write.
  - L_LOAD + byte_valid: in the next cycle, wr_en=1, wr_data=byte, wr_addr=current address.
    - In the cycle after the write, wr_addr increments by 1.
    - wr_addr and wr_data hold between writes; wr_en is otherwise 0.
  - Write of address NUM_PIXELS-1: the next cycle enters L_DONE with busy=0 and frame_done=1. wr_addr wraps to 0 with no further writes.
  - start while in L_LOAD: restart at address 0. The partial frame stays in RAM and is overwritten.
  - start and byte_valid in the same cycle: start wins and the byte is discarded. The first write after restart goes to address 0.
- Latency: the pin edge at the centre of the stop bit to wr_en is 2 (sync) + 1 (stop sample) + 1 (write register) cycles.
- The RX FSM runs independently of the loader state. start does not reset the RX FSM.
- Throughput: at most 1 write per 10*CLKS_PER_BIT cycles. The RAM port needs no backpressure.

Optional Feature:
Macro FRAME_CHECKSUM_EN.
- Defined:
  - Adds output port checksum [7:0], reset value 0.
  - checksum is cleared on start. Each written pixel is added modulo 256, updated in the same cycle wr_en is high.
  - The value is final and stable once frame_done=1. It is used for a host-side integrity check.
- Undefined: no checksum port and no adder logic. All other behaviour is identical.

Test Plan:
1. Parameter override CLK_HZ=50000000, BAUD=6250000 (CLKS_PER_BIT=8), NUM_PIXELS=4. Pulse start, send 0x12 0x34 0x56 0x78 -> writes (0,0x12)(1,0x34)(2,0x56)(3,0x78), each wr_en exactly 1 cycle. Then frame_done=1, busy=0; checksum=0x14 if FRAME_CHECKSUM_EN.
2. With no start pulse, send 0xAA -> no wr_en, busy=0, frame_done=0.
3. In L_LOAD, send byte 0x55 with stop bit forced low -> no write, frame_err=1, wr_addr unchanged. Hold rx=0 for 40 cycles, then release and send 0x01 -> write (addr, 0x01) with no spurious 0x00 writes.
4. rx low pulse of 3 cycles (shorter than half a bit) in L_LOAD -> no write, no frame_err.
5. After 2 bytes are written, pulse start in the same cycle as the 3rd byte_valid -> that byte is dropped. The next byte 0x9C is written at address 0 and frame_err is cleared.
6. Assert rst_n=0 mid-byte while in L_LOAD -> all outputs are 0 immediately, without waiting for a clock edge. After release, a full 4-byte frame loads correctly from address 0.
